// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   md_fn_t    : operation select, RV32M/RV64M funct3 encoding
//   md_state_t : control states of muldiv_unit
//   helpers    : operation classification used at accept and fixup time
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } md_fn_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } md_state_t;

  function automatic logic md_is_div(input md_fn_t fn);
    return fn inside {DIV, DIVU, REM, REMU};
  endfunction

  function automatic logic md_is_rem(input md_fn_t fn);
    return fn inside {REM, REMU};
  endfunction

  function automatic logic md_is_mulh(input md_fn_t fn);
    return fn inside {MULH, MULHSU, MULHU};
  endfunction

  function automatic logic md_a_signed(input md_fn_t fn);
    return fn inside {MULH, MULHSU, DIV, REM};
  endfunction

  function automatic logic md_b_signed(input md_fn_t fn);
    return fn inside {MULH, DIV, REM};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath (purely combinational).
//   acc_i    : 2*WIDTH accumulator {high half, low half}
//   opnd_i   : multiplicand (multiply) or divisor (divide), magnitude only
//   is_div_i : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_o    : accumulator after this iteration
// Multiply: low half holds the remaining multiplier bits, LSB first; the
//   partial sum lives in the high half and the whole thing shifts right.
// Divide: low half holds the dividend, MSB first; it shifts left into the
//   partial remainder while quotient bits fill in from the bottom.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  logic               is_div_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   add_sum;
  logic [2*WIDTH:0] add_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  always_comb begin
    // Carry out of the add is kept so the right shift does not lose it.
    add_sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    add_shift = {add_sum, acc_i[WIDTH-1:0]};

    // Remainder is always below the divisor, so trial < 2*divisor and the
    // top bit of diff is a clean borrow flag.
    trial = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    diff  = trial - {1'b0, opnd_i};

    if (is_div_i) begin
      if (diff[WIDTH]) begin
        acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end else begin
        acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_o = add_shift[2*WIDTH:1];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit for the execute stage.
//   clk, rst_n           : clock, asynchronous active-low reset
//   flush                : squash any in-flight or unconsumed operation
//   in_valid/in_ready    : request handshake; fn, a, b sampled on accept
//   out_valid/out_ready  : result handshake; out is registered and stable
//   busy                 : high whenever the unit is not idle
// Operands are reduced to magnitudes at accept, iterated WIDTH times by
// muldiv_step, then sign-corrected in a single FIXUP cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  md_fn_t           fn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  md_state_t          state_q, state_d;
  md_fn_t             fn_q, fn_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   out_q, out_d;

  logic               is_div;
  logic [2*WIDTH-1:0] step_acc;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               div_zero, div_ovf;
  logic [WIDTH-1:0]   spec_res;
  logic [2*WIDTH-1:0] fix_src, fix_val;
  logic [WIDTH-1:0]   fix_res;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  assign is_div = md_is_div(fn_q);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .is_div_i (is_div),
    .acc_o    (step_acc)
  );

  // ---- accept: magnitudes, result sign and divide special cases ----
  always_comb begin
    sign_a   = md_a_signed(fn) & a[WIDTH-1];
    sign_b   = md_b_signed(fn) & b[WIDTH-1];
    abs_a    = neg_w(a, sign_a);
    abs_b    = neg_w(b, sign_b);
    div_zero = md_is_div(fn) && (b == '0);
    div_ovf  = (fn == DIV || fn == REM) && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    if (div_zero) begin
      spec_res = md_is_rem(fn) ? a : '1;
    end else begin
      spec_res = md_is_rem(fn) ? '0 : a;
    end
  end

  // ---- fixup: sign correction and result half selection ----
  always_comb begin
    // Low bits of a negation depend only on low bits, so a divide result
    // can ride through the same 2*WIDTH negator zero-extended.
    if (is_div) begin
      fix_src = {{WIDTH{1'b0}}, md_is_rem(fn_q) ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0]};
    end else begin
      fix_src = acc_q;
    end
    fix_val = neg_2w(fix_src, neg_q);
    fix_res = md_is_mulh(fn_q) ? fix_val[2*WIDTH-1:WIDTH] : fix_val[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    fn_d    = fn_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    out_d   = out_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            fn_d   = fn;
            opnd_d = abs_b;
            acc_d  = {{WIDTH{1'b0}}, abs_a};
            neg_d  = md_is_rem(fn) ? sign_a : (sign_a ^ sign_b);
            cnt_d  = CW'(WIDTH - 1);
            if (div_zero || div_ovf) begin
              out_d   = spec_res;
              state_d = ST_DONE;
            end else begin
              state_d = ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          acc_d = step_acc;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = ST_FIXUP;
        end
        ST_FIXUP: begin
          out_d   = fix_res;
          state_d = ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      fn_q    <= MUL;
      cnt_q   <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      fn_q    <= fn_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out       = out_q;

endmodule
